// File: rtl/tb_mem_bank_model.sv
// tb_mem_bank_model: behavioural model of NUM_BANKS independent single-port
// SRAM banks. Each bank has a pipelined read path with RD_LATENCY cycles of
// latency and a saturating 16-bit read counter. An optional error injector
// flips bit 0, and optionally bit 1, of one future read on a selected bank.
//
// Optional feature macro: TB_MEM_ERR_INJ_EN (error injection). When it is
// undefined, the inj_* inputs are ignored and inj_pending is tied low.
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset (memory contents are kept)
//   clken         per-bank access enable
//   wren_bank     per-bank write enable, qualified by clken
//   addr_bank     per-bank word address, bank i in slice i
//   wr_data_bank  per-bank write data
//   bank_dout     per-bank read data, held between reads
//   dout_valid    per-bank one-cycle pulse when new read data appears
//   rd_cnt        per-bank saturating read counters (16 bits each)
//   inj_req/inj_bank/inj_double/inj_pending  error-injection control

module tb_mem_bank_model_bank #(
  parameter int DW = 39,
  parameter int AW = 10,
  parameter int L  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    flip,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [15:0]   rd_cnt
);
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [L:1]    vld_pipe;
  logic [DW-1:0] dat_pipe [1:L];

  // Memory has no reset; it must survive rst.
  always_ff @(posedge clk)
    if (wr) mem[addr] <= wr_data;

  // Each data stage loads only when a valid word passes through, so the last
  // stage naturally holds the most recent read value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 1; s <= L; s++) dat_pipe[s] <= '0;
    end else begin
      vld_pipe[1] <= go;
      if (go) dat_pipe[1] <= mem[addr] ^ {{(DW-2){1'b0}}, flip};
      for (int s = 2; s <= L; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                          rd_cnt <= '0;
    else if (go && rd_cnt != 16'hFFFF) rd_cnt <= rd_cnt + 16'd1;
  end

  assign dout       = dat_pipe[L];
  assign dout_valid = vld_pipe[L];
endmodule

module tb_mem_bank_model #(
  parameter int NUM_BANKS       = 4,
  parameter int DATA_WIDTH      = 39,
  parameter int BANK_ADDR_WIDTH = 10,
  parameter int RD_LATENCY      = 1,
  localparam int IW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_BANKS-1:0]                 clken,
  input  logic [NUM_BANKS-1:0]                 wren_bank,
  input  logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0] addr_bank,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]      wr_data_bank,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]      bank_dout,
  output logic [NUM_BANKS-1:0]                 dout_valid,
  output logic [NUM_BANKS*16-1:0]              rd_cnt,
  input  logic                                 inj_req,
  input  logic [IW-1:0]                        inj_bank,
  input  logic                                 inj_double,
  output logic                                 inj_pending
);
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_lat
    $error("RD_LATENCY must be 1..4");
  end
  if (NUM_BANKS < 1 || NUM_BANKS > 16) begin : g_bad_nb
    $error("NUM_BANKS must be 1..16");
  end

  logic [NUM_BANKS-1:0]      go, wr;
  logic [NUM_BANKS-1:0][1:0] flip;

  // Accesses during reset are dropped entirely.
  assign go = clken & ~wren_bank & {NUM_BANKS{~rst}};
  assign wr = clken &  wren_bank & {NUM_BANKS{~rst}};

`ifdef TB_MEM_ERR_INJ_EN
  logic          pend, dbl_q, hit;
  logic [IW-1:0] bank_q;
  logic [NUM_BANKS-1:0] sel;

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_sel
    assign sel[i]  = pend && (bank_q == IW'(i));
    assign flip[i] = sel[i] ? {dbl_q, 1'b1} : 2'b00;
  end
  assign hit = |(sel & go);

  // A request is taken only when idle, so the read on the target bank in the
  // same cycle as the request is never corrupted.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend   <= 1'b0;
      bank_q <= '0;
      dbl_q  <= 1'b0;
    end else if (!pend) begin
      if (inj_req && ({1'b0, inj_bank} < (IW+1)'(NUM_BANKS))) begin
        pend   <= 1'b1;
        bank_q <= inj_bank;
        dbl_q  <= inj_double;
      end
    end else if (hit) begin
      pend <= 1'b0;
    end
  end
  assign inj_pending = pend;
`else
  logic unused_inj;
  assign unused_inj  = ^{inj_req, inj_bank, inj_double};
  assign flip        = '0;
  assign inj_pending = 1'b0;
`endif

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    tb_mem_bank_model_bank #(
      .DW(DATA_WIDTH), .AW(BANK_ADDR_WIDTH), .L(RD_LATENCY)
    ) u_bank (
      .clk        (clk),
      .rst        (rst),
      .go         (go[i]),
      .wr         (wr[i]),
      .addr       (addr_bank[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH]),
      .wr_data    (wr_data_bank[i*DATA_WIDTH +: DATA_WIDTH]),
      .flip       (flip[i]),
      .dout       (bank_dout[i*DATA_WIDTH +: DATA_WIDTH]),
      .dout_valid (dout_valid[i]),
      .rd_cnt     (rd_cnt[i*16 +: 16])
    );
  end
endmodule

// File: tb/tb_tb_mem_bank_model.sv
// Scoreboard bench for tb_mem_bank_model (RD_LATENCY=3, 4 banks). Each issued
// read pushes its expected word and due cycle; a negedge monitor pops and
// compares whenever dout_valid pulses. Expected injection results follow
// TB_MEM_ERR_INJ_EN.
module tb_tb_mem_bank_model;
  localparam int NB = 4, DW = 39, AW = 10, LAT = 3;
`ifdef TB_MEM_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NB-1:0]    clken, wren_bank, dout_valid;
  logic [NB*AW-1:0] addr_bank;
  logic [NB*DW-1:0] wr_data_bank, bank_dout;
  logic [NB*16-1:0] rd_cnt;
  logic             inj_req, inj_double, inj_pending;
  logic [1:0]       inj_bank;

  typedef struct { logic [DW-1:0] data; int due; } exp_t;
  exp_t exp_q [NB][$];
  int errors = 0, checks = 0, cyc = 0;
  int cnt_m [NB];

  tb_mem_bank_model #(
    .NUM_BANKS(NB), .DATA_WIDTH(DW), .BANK_ADDR_WIDTH(AW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .clken(clken), .wren_bank(wren_bank),
    .addr_bank(addr_bank), .wr_data_bank(wr_data_bank),
    .bank_dout(bank_dout), .dout_valid(dout_valid), .rd_cnt(rd_cnt),
    .inj_req(inj_req), .inj_bank(inj_bank), .inj_double(inj_double),
    .inj_pending(inj_pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest outstanding read on
  // that bank, both in data and in cycle.
  always @(negedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (dout_valid[b] === 1'b1) begin
        exp_t e;
        if (exp_q[b].size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid b%0d: got data %0h want no pulse",
                   b, bank_dout[b*DW +: DW]);
        end else begin
          e = exp_q[b].pop_front();
          chk($sformatf("rd_data b%0d", b), bank_dout[b*DW +: DW], e.data);
          chk($sformatf("rd_cycle b%0d", b), cyc, e.due);
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic wait_n(int n); repeat (n) tick(); endtask
  task automatic idle(); clken = '0; wren_bank = '0; inj_req = 1'b0; endtask

  task automatic wr(int b, int a, logic [DW-1:0] d);
    clken[b] = 1'b1; wren_bank[b] = 1'b1;
    addr_bank[b*AW +: AW] = AW'(a); wr_data_bank[b*DW +: DW] = d;
  endtask

  task automatic rd(int b, int a, logic [DW-1:0] d, bit push = 1'b1);
    exp_t t;
    clken[b] = 1'b1; wren_bank[b] = 1'b0;
    addr_bank[b*AW +: AW] = AW'(a);
    if (push) begin
      t.data = d; t.due = cyc + LAT;
      exp_q[b].push_back(t);
      cnt_m[b]++;
    end
  endtask

  task automatic chk_reset_state(string tag);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("%s_dout b%0d", tag, b), bank_dout[b*DW +: DW], 0);
      chk($sformatf("%s_rdcnt b%0d", tag, b), rd_cnt[b*16 +: 16], 0);
    end
    chk($sformatf("%s_valid", tag), dout_valid, 0);
    chk($sformatf("%s_pending", tag), inj_pending, 0);
  endtask

  initial begin
    rst = 1'b1; idle();
    addr_bank = '0; wr_data_bank = '0; inj_bank = '0; inj_double = 1'b0;
    for (int b = 0; b < NB; b++) cnt_m[b] = 0;
    wait_n(3);
    rst = 1'b0;
    chk_reset_state("reset");

    // Write then read next cycle, latency 3.
    wr(2, 'h10, 'h55AA5); tick(); idle();
    rd(2, 'h10, 'h55AA5); tick(); idle();
    wait_n(LAT + 1);

    // Back-to-back reads, results every cycle in order.
    for (int i = 0; i < 4; i++) begin wr(0, i, DW'('hA + i)); tick(); idle(); end
    for (int i = 0; i < 4; i++) begin rd(0, i, DW'('hA + i)); tick(); end
    idle(); wait_n(LAT + 1);

    // Concurrent write on bank 1 and read on bank 3.
    wr(1, 5, 'h1234); tick(); idle();
    rd(1, 5, 'h1234); tick(); idle();
    wr(3, 7, 'h7777); tick(); idle();
    wait_n(LAT + 1);
    wr(1, 5, 'h9999); rd(3, 7, 'h7777); tick(); idle();
    wait_n(LAT + 1);
    chk("hold_b1", bank_dout[1*DW +: DW], 'h1234);
    rd(1, 5, 'h9999); tick(); idle();

    // Write enable without clken is ignored.
    wren_bank[3] = 1'b1; addr_bank[3*AW +: AW] = AW'(7);
    wr_data_bank[3*DW +: DW] = 'hBAD; tick(); idle();
    rd(3, 7, 'h7777); tick(); idle();
    wait_n(LAT + 1);
    for (int b = 0; b < NB; b++)
      chk($sformatf("rd_cnt b%0d", b), rd_cnt[b*16 +: 16], cnt_m[b]);

    // Error injection: same-cycle read clean, other bank clean, second
    // request while pending ignored, target read flipped, memory intact.
    wr(1, 0, 0); tick(); idle();
    inj_req = 1'b1; inj_bank = 2'd1; inj_double = 1'b1;
    rd(1, 0, 0); tick(); idle();
    chk("inj_pending_set", inj_pending, INJ);
    inj_req = 1'b1; inj_bank = 2'd3; inj_double = 1'b0;
    rd(2, 'h10, 'h55AA5); tick(); idle();
    chk("inj_pending_hold", inj_pending, INJ);
    rd(1, 0, INJ ? DW'(3) : DW'(0)); tick(); idle();
    chk("inj_pending_clr", inj_pending, 0);
    rd(1, 0, 0); tick(); idle();
    rd(3, 7, 'h7777); tick(); idle();
    wait_n(LAT + 1);

    // Reset one cycle after a read: the read is discarded, accesses under
    // reset are ignored, memory survives.
    rd(0, 0, 0, 1'b0); tick(); idle();
    rst = 1'b1; rd(2, 'h10, 0, 1'b0); wr(0, 1, 'hEEEE); tick(); idle();
    rst = 1'b0;
    for (int b = 0; b < NB; b++) cnt_m[b] = 0;
    chk_reset_state("rst_inflight");
    wait_n(LAT + 2);
    rd(0, 0, 'hA); tick();
    rd(0, 1, 'hB); tick(); idle();
    wait_n(LAT + 1);
    chk("rd_cnt_post_rst b2", rd_cnt[2*16 +: 16], 0);

    // Counter saturation.
    repeat (32'h10005) begin rd(0, 0, 'hA); tick(); end
    idle(); wait_n(LAT + 1);
    chk("rd_cnt_sat b0", rd_cnt[15:0], 16'hFFFF);

    for (int b = 0; b < NB; b++)
      chk($sformatf("queue_empty b%0d", b), exp_q[b].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
